// File: rtl/ema_magnitude_filter_pkg.sv
// ema_magnitude_filter_pkg: shared FSM states, width defaults and clog2 helper
package ema_magnitude_filter_pkg;
   typedef enum logic [1:0] {EMPTY, WARMUP, TRACK} state_t;
   localparam int W_IN_DEF = 27;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/ema_magnitude_filter_if.sv
// ema_magnitude_filter_if: magnitude sample stream in, smoothed level out
interface ema_magnitude_filter_if
   import ema_magnitude_filter_pkg::*;
   #(parameter int W_IN = W_IN_DEF);
   logic            valid_in;
   logic [W_IN-1:0] mag_in;
   logic            clear;
   logic            valid_out;
   logic [W_IN-1:0] avg_out;
   logic            settled;
   modport master (output valid_in, mag_in, clear, input valid_out, avg_out, settled);
   modport slave  (input valid_in, mag_in, clear, output valid_out, avg_out, settled);
endinterface

// File: rtl/ema_magnitude_filter_settle_counter.sv
// ema_magnitude_filter_settle_counter: accepted-sample count with terminal compare
module ema_magnitude_filter_settle_counter #(
   parameter int TERM = 64,
   parameter int CW = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic seed,
   input  logic inc,
   output logic term
);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clear) cnt <= '0;
      else if (seed) cnt <= CW'(1);
      else if (inc) cnt <= cnt + CW'(1);
   end
   assign term = cnt == CW'(TERM - 1);
endmodule

// File: rtl/ema_magnitude_filter.sv
// ema_magnitude_filter: EMA (alpha = 2^-K) of magnitude stream with settle flag
module ema_magnitude_filter
   import ema_magnitude_filter_pkg::*;
   #(
   parameter int W_IN = W_IN_DEF,
   parameter int K = 4,
   parameter int SETTLE = 4
) (
   input logic clk,
   input logic rst,
   ema_magnitude_filter_if.slave bus
);
   localparam int ACC_W = W_IN + K;
   localparam int TERM = SETTLE << K;
   localparam int CW = clog2(TERM) + 1;
   state_t state, state_n;
   logic [ACC_W-1:0] acc;
   logic valid_q, seed, upd, term;
   always_comb begin
      state_n = state;
      seed = 1'b0;
      upd = 1'b0;
      if (bus.clear) state_n = EMPTY;
      else if (bus.valid_in) begin
         seed = state == EMPTY;
         upd = state != EMPTY;
         state_n = state == EMPTY ? WARMUP : (state == WARMUP && term) ? TRACK : state;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else state <= state_n;
   end
   // acc holds avg<<K; steady-state bound (2^W_IN-1)<<K keeps it from wrapping
   always_ff @(posedge clk) begin
      if (rst || bus.clear) acc <= '0;
      else if (seed) acc <= {bus.mag_in, K'(0)};
      else if (upd) acc <= acc - (acc >> K) + ACC_W'(bus.mag_in);
   end
   always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else valid_q <= bus.valid_in && !bus.clear;
   end
   ema_magnitude_filter_settle_counter #(.TERM(TERM), .CW(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.clear),
      .seed  (seed),
      .inc   (upd && state == WARMUP),
      .term  (term)
   );
   assign bus.valid_out = valid_q;
   assign bus.avg_out = acc[ACC_W-1:K];
   assign bus.settled = state == TRACK;
endmodule

// File: tb/tb_ema_magnitude_filter.sv
// tb_ema_magnitude_filter: directed vectors for the magnitude EMA filter
module tb_ema_magnitude_filter;
   logic clk = 1'b0;
   logic rst;
   int n_vec = 0;
   int n_bad = 0;
   ema_magnitude_filter_if #(.W_IN(27)) bus ();
   ema_magnitude_filter #(.W_IN(27), .K(4), .SETTLE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic v, input logic [26:0] m, input logic c);
      bus.valid_in = v;
      bus.mag_in = m;
      bus.clear = c;
      @(posedge clk);
      #1;
   endtask
   task automatic expect_out(input string tag, input logic vo, input logic [26:0] avg, input logic st);
      chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(vo));
      chk({tag, ".avg_out"}, 32'(bus.avg_out), 32'(avg));
      chk({tag, ".settled"}, 32'(bus.settled), 32'(st));
   endtask
   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 27'd500, 1'b0);
         expect_out("reset", 1'b0, 27'd0, 1'b0);
      end
      rst = 1'b0;
      cyc(1'b1, 27'd1000, 1'b0);
      expect_out("seed1000", 1'b1, 27'd1000, 1'b0);
      cyc(1'b0, 27'd0, 1'b0);
      expect_out("hold", 1'b0, 27'd1000, 1'b0);
      cyc(1'b0, 27'd0, 1'b1);
      expect_out("clear1", 1'b0, 27'd0, 1'b0);
      cyc(1'b1, 27'd0, 1'b0);
      expect_out("seed0", 1'b1, 27'd0, 1'b0);
      cyc(1'b1, 27'd1600, 1'b0);
      expect_out("step1", 1'b1, 27'd100, 1'b0);
      cyc(1'b1, 27'd1600, 1'b0);
      expect_out("step2", 1'b1, 27'd193, 1'b0);
      cyc(1'b0, 27'd0, 1'b1);
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 27'd777, 1'b0);
         expect_out($sformatf("const%0d", i), 1'b1, 27'd777, i == 63);
      end
      cyc(1'b0, 27'd0, 1'b0);
      expect_out("settled_hold", 1'b0, 27'd777, 1'b1);
      cyc(1'b1, 27'd777, 1'b0);
      expect_out("track", 1'b1, 27'd777, 1'b1);
      cyc(1'b1, 27'd9, 1'b1);
      expect_out("clear_wins", 1'b0, 27'd0, 1'b0);
      cyc(1'b1, 27'd9, 1'b0);
      expect_out("reseed9", 1'b1, 27'd9, 1'b0);
      cyc(1'b0, 27'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 27'h7FF_FFFF, 1'b0);
         expect_out($sformatf("max%0d", i), 1'b1, 27'd134217727, 1'b0);
      end
      bus.valid_in = 1'b1;
      bus.mag_in = 27'd50;
      bus.clear = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_out("rst_mid", 1'b0, 27'd0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
